// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types and encodings for the RV32I multicycle control unit.
// Contents: FSM state enum, opcode constants, ALUOp/ALUControl, ResultSrc, ALUSrcA/B and
// ImmSrc encodings, and the immediate-type decode helper.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq,
    StTrap
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate type depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: ALU decoder for the multicycle control unit.
// Ports:
//   alu_op_i      ALUOp from the FSM (add / sub / funct-decoded)
//   funct3_i      Instr[14:12]
//   op5_i         Instr[5], distinguishes R-type from I-type
//   funct7b5_i    Instr[30]
//   alu_control_o ALU operation select
//   bad_funct_o   funct3 is not one of the supported ALU functions
module mc_aludec
  import riscv_mc_pkg::*;
(
  input  aluop_e     alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       bad_funct_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unique case (alu_op_i)
      AluOpAdd: alu_control_o = ALU_ADD;
      AluOpSub: alu_control_o = ALU_SUB;
      AluOpFunct: begin
        case (funct3_i)
          // Only R-type uses funct7b5 to select sub; for I-type it is an immediate bit.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

  // Evaluated independently of alu_op_i so DECODE can trap before EXECUTE.
  assign bad_funct_o = !(funct3_i inside {3'b000, 3'b010, 3'b110, 3'b111});

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore control FSM for the RV32I shared-memory multicycle datapath.
// Supports lw, sw, R-type ALU, I-type ALU, beq and jal; stalls on mem_ready in FETCH,
// MEMREAD and MEMWRITE; unsupported encodings enter TRAP and raise the sticky illegal flag.
// Ports:
//   clk, reset (async, active-low)   op, funct3, funct7b5, Zero, mem_ready   (inputs)
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
//   ALUControl, RegWrite, illegal                                         (outputs)
// Optional feature: define RISCV_MC_PERF_EN to add the 32-bit retired-instruction counter
// output instret.
module riscv_multicycle_ctrl
  import riscv_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        RegWrite,
  output logic        illegal
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [31:0] instret
`endif
);

  state_e state_q, state_d;
  logic   illegal_q;

  aluop_e     alu_op;
  logic       bad_funct;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  mc_aludec u_aludec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl),
    .bad_funct_o   (bad_funct)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (op == OP_LW || op == OP_SW)  state_d = StMemAdr;
        else if (op == OP_R)             state_d = bad_funct ? StTrap : StExecR;
        else if (op == OP_I)             state_d = bad_funct ? StTrap : StExecI;
        else if (op == OP_BEQ)           state_d = (funct3 == 3'b000) ? StBeq : StTrap;
        else if (op == OP_JAL)           state_d = StJal;
        else                             state_d = StTrap;
      end
      StMemAdr:   state_d = (op == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBeq:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // Moore outputs, with mem_ready gating in FETCH and Zero gating in BEQ
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      StDecode: begin
        // Branch target PC+imm is precomputed into ALUOut here.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      StMemAdr: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StJal: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      StBeq: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = AluOpSub;
        pc_write  = Zero;
      end
      default: ;
    endcase
  end

  // Strobes are masked by the async reset so nothing fires while it is held low.
  assign PCWrite   = pc_write  & reset;
  assign IRWrite   = ir_write  & reset;
  assign MemWrite  = mem_write & reset;
  assign RegWrite  = reg_write & reset;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ImmSrc    = imm_src_of(op);
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

`ifdef RISCV_MC_PERF_EN
  logic [31:0] instret_q;
  logic        retire;

  // Every completing state returns to FETCH; TRAP never does, so it is never counted.
  assign retire = (state_d == StFetch) &&
                  (state_q inside {StMemWb, StMemWrite, StAluWb, StBeq});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule
